// File: rtl/evg_frame_gen.sv
// evg_frame_gen: 16-bit / 2-K-flag 8b10b word generator for the SFP GTP transmitter.
//
// Event lane  (tx_data[7:0],  tx_charisk[0]): K28.5 commas every COMMA_PERIOD words,
//   optional 0x7E beacons every BEACON_PERIOD words, otherwise handshaked event codes.
// Data lane   (tx_data[15:8], tx_charisk[1]): even words carry the distributed bus,
//   odd words carry segmented-data-buffer frames:
//   START(K28.2) ADDR DATA[SEG_BYTES] STOP(K28.1) CSUM_H CSUM_L, then GAP_SLOTS idle slots.
//
// Ports:
//   tx_clk              GTP TX user clock
//   aresetn             synchronous active-low reset
//   en                  generator enable (GTP TX reset done)
//   dbus                distributed-bus byte, sampled on bus slots
//   ev_valid/ev_code    event request / code;  ev_ready: accepted this cycle
//   seg_valid/seg_addr/seg_data  frame offer;  seg_ready: hold register empty
//   tx_data/tx_charisk  registered word stream to the transmitter
//   busy                frame FSM not idle
//   frame_cnt           completed frames, wraps 0xFFFF -> 0
module evg_frame_gen #(
    parameter int SEG_BYTES     = 16,
    parameter int COMMA_PERIOD  = 4,
    parameter int BEACON_PERIOD = 0,
    parameter int GAP_SLOTS     = 2
) (
    input  logic                   tx_clk,
    input  logic                   aresetn,
    input  logic                   en,
    input  logic [7:0]             dbus,
    input  logic                   ev_valid,
    input  logic [7:0]             ev_code,
    output logic                   ev_ready,
    input  logic                   seg_valid,
    input  logic [7:0]             seg_addr,
    input  logic [SEG_BYTES*8-1:0] seg_data,
    output logic                   seg_ready,
    output logic [15:0]            tx_data,
    output logic [1:0]             tx_charisk,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);

    localparam logic [7:0] K28_5  = 8'hBC;
    localparam logic [7:0] BEACON = 8'h7E;
    localparam logic [7:0] K_STRT = 8'h5C;
    localparam logic [7:0] K_STOP = 8'h3C;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_CSUM_H = 3'd4,
        ST_CSUM_L = 3'd5,
        ST_GAP    = 3'd6
    } state_t;

    logic [15:0]            wc_r;
    logic [15:0]            bc_r;
    logic                   phase_r;
    state_t                 state_r;
    state_t                 state_s;
    logic                   hold_full_r;
    logic [7:0]             hold_addr_r;
    logic [SEG_BYTES*8-1:0] hold_data_r;
    logic [7:0]             work_addr_r;
    logic [SEG_BYTES*8-1:0] work_data_r;
    logic [6:0]             byte_cnt_r;
    logic [6:0]             byte_cnt_s;
    logic [15:0]            gap_cnt_r;
    logic [15:0]            gap_cnt_s;
    logic [15:0]            sum_r;
    logic [15:0]            sum_s;
    logic [15:0]            csum_s;
    logic [15:0]            frame_cnt_r;
    logic [15:0]            tx_data_r;
    logic [1:0]             tx_charisk_r;
    logic                   busy_r;

    logic                   comma_s;
    logic                   beacon_s;
    logic                   seg_acc_s;
    logic                   load_s;
    logic                   shift_s;
    logic                   frame_inc_s;
    logic [7:0]             ev_byte_s;
    logic                   ev_k_s;
    logic [7:0]             fsm_byte_s;
    logic                   fsm_k_s;
    logic [7:0]             dl_byte_s;
    logic                   dl_k_s;

    assign comma_s   = (wc_r == 16'd0);
    assign beacon_s  = (BEACON_PERIOD != 0) && (bc_r == 16'd0);
    // Handshakes are gated by reset so nothing appears ready while the block is held in reset.
    assign ev_ready  = aresetn & en & ~comma_s & ~beacon_s;
    assign seg_ready = aresetn & en & ~hold_full_r;
    assign seg_acc_s = seg_valid & seg_ready;
    assign csum_s    = 16'hFFFF - sum_r;

    assign tx_data    = tx_data_r;
    assign tx_charisk = tx_charisk_r;
    assign busy       = busy_r;
    assign frame_cnt  = frame_cnt_r;

    // Event-lane priority: comma, then beacon, then event code, else idle.
    always_comb begin
        ev_byte_s = 8'h00;
        ev_k_s    = 1'b0;
        if (comma_s) begin
            ev_byte_s = K28_5;
            ev_k_s    = 1'b1;
        end else if (beacon_s) begin
            ev_byte_s = BEACON;
        end else if (ev_valid) begin
            ev_byte_s = ev_code;
        end else begin
            ev_byte_s = 8'h00;
        end
    end

    // Frame FSM next state and frame-slot byte; it only moves on frame slots while enabled.
    always_comb begin
        state_s     = state_r;
        fsm_byte_s  = 8'h00;
        fsm_k_s     = 1'b0;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        frame_inc_s = 1'b0;
        sum_s       = sum_r;
        byte_cnt_s  = byte_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        if (en && phase_r) begin
            case (state_r)
                ST_IDLE: begin
                    // START is emitted in the same slot that takes the frame from the hold.
                    if (hold_full_r) begin
                        load_s     = 1'b1;
                        fsm_byte_s = K_STRT;
                        fsm_k_s    = 1'b1;
                        sum_s      = 16'd0;
                        state_s    = ST_ADDR;
                    end else begin
                        state_s    = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    fsm_byte_s = work_addr_r;
                    sum_s      = {8'd0, work_addr_r};
                    byte_cnt_s = 7'd0;
                    state_s    = ST_DATA;
                end
                ST_DATA: begin
                    fsm_byte_s = work_data_r[7:0];
                    sum_s      = sum_r + {8'd0, work_data_r[7:0]};
                    shift_s    = 1'b1;
                    if (byte_cnt_r == 7'(SEG_BYTES - 1)) begin
                        state_s = ST_STOP;
                    end else begin
                        byte_cnt_s = byte_cnt_r + 7'd1;
                    end
                end
                ST_STOP: begin
                    fsm_byte_s = K_STOP;
                    fsm_k_s    = 1'b1;
                    state_s    = ST_CSUM_H;
                end
                ST_CSUM_H: begin
                    fsm_byte_s = csum_s[15:8];
                    state_s    = ST_CSUM_L;
                end
                ST_CSUM_L: begin
                    fsm_byte_s  = csum_s[7:0];
                    frame_inc_s = 1'b1;
                    gap_cnt_s   = 16'd0;
                    if (GAP_SLOTS == 0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 16'(GAP_SLOTS - 1)) begin
                        state_s = ST_IDLE;
                    end else begin
                        gap_cnt_s = gap_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Data-lane mux: bus slot on phase 0, frame slot on phase 1.
    always_comb begin
        if (phase_r) begin
            dl_byte_s = fsm_byte_s;
            dl_k_s    = fsm_k_s;
        end else begin
            dl_byte_s = dbus;
            dl_k_s    = 1'b0;
        end
    end

    // Slot counters, FSM state, working frame and the registered output word.
    always_ff @(posedge tx_clk) begin
        if (!aresetn || !en) begin
            wc_r         <= 16'd0;
            bc_r         <= 16'd0;
            phase_r      <= 1'b0;
            state_r      <= ST_IDLE;
            byte_cnt_r   <= 7'd0;
            gap_cnt_r    <= 16'd0;
            sum_r        <= 16'd0;
            tx_data_r    <= 16'd0;
            tx_charisk_r <= 2'b00;
            busy_r       <= 1'b0;
        end else begin
            wc_r <= (wc_r == 16'(COMMA_PERIOD - 1)) ? 16'd0 : wc_r + 16'd1;
            if (BEACON_PERIOD == 0) begin
                bc_r <= 16'd0;
            end else begin
                bc_r <= (bc_r == 16'(BEACON_PERIOD - 1)) ? 16'd0 : bc_r + 16'd1;
            end
            phase_r      <= ~phase_r;
            state_r      <= state_s;
            byte_cnt_r   <= byte_cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            sum_r        <= sum_s;
            tx_data_r    <= {dl_byte_s, ev_byte_s};
            tx_charisk_r <= {dl_k_s, ev_k_s};
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    // Working copy of the frame; data shifts down one byte per DATA slot.
    always_ff @(posedge tx_clk) begin
        if (!aresetn) begin
            work_addr_r <= 8'd0;
            work_data_r <= '0;
        end else if (load_s) begin
            work_addr_r <= hold_addr_r;
            work_data_r <= hold_data_r;
        end else if (shift_s) begin
            work_data_r <= work_data_r >> 8;
        end else begin
            work_data_r <= work_data_r;
        end
    end

    // Hold register: survives en=0, emptied when the FSM takes the frame.
    always_ff @(posedge tx_clk) begin
        if (!aresetn) begin
            hold_full_r <= 1'b0;
            hold_addr_r <= 8'd0;
            hold_data_r <= '0;
        end else if (load_s) begin
            hold_full_r <= 1'b0;
        end else if (seg_acc_s) begin
            hold_full_r <= 1'b1;
            hold_addr_r <= seg_addr;
            hold_data_r <= seg_data;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // Completed-frame counter; only reset clears it, en=0 leaves it alone.
    always_ff @(posedge tx_clk) begin
        if (!aresetn) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_inc_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

endmodule

// File: tb/tb_evg_frame_gen.sv
// Scoreboard bench for evg_frame_gen. A word-level reference model predicts every
// output word from slot arithmetic and a queue of frame bytes; a monitor compares.
module tb_evg_frame_gen;

    localparam int SB = 16;
    localparam int CP = 4;
    localparam int BP = 7;
    localparam int GS = 2;

    logic            tx_clk;
    logic            aresetn;
    logic            en;
    logic [7:0]      dbus;
    logic            ev_valid;
    logic [7:0]      ev_code;
    logic            ev_ready;
    logic            seg_valid;
    logic [7:0]      seg_addr;
    logic [SB*8-1:0] seg_data;
    logic            seg_ready;
    logic [15:0]     tx_data;
    logic [1:0]      tx_charisk;
    logic            busy;
    logic [15:0]     frame_cnt;

    evg_frame_gen #(
        .SEG_BYTES(SB), .COMMA_PERIOD(CP), .BEACON_PERIOD(BP), .GAP_SLOTS(GS)
    ) dut (
        .tx_clk(tx_clk), .aresetn(aresetn), .en(en), .dbus(dbus),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
        .seg_valid(seg_valid), .seg_addr(seg_addr), .seg_data(seg_data),
        .seg_ready(seg_ready), .tx_data(tx_data), .tx_charisk(tx_charisk),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
        logic        b;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hs_cnt  = 0;
    int   ev11_cnt = 0;

    // stimulus for the next cycle
    logic            s_rstn = 1'b0, s_en = 1'b0, s_evv = 1'b0, s_sv = 1'b0, s_glitch = 1'b0;
    logic [7:0]      s_dbus = 8'h00, s_evc = 8'h00, s_sa = 8'h00;
    logic [SB*8-1:0] s_sd = '0;

    // reference model state
    int              m_k = 0;
    int              m_slots[$];
    logic            m_hold_full = 1'b0;
    logic [7:0]      m_hold_addr = 8'h00;
    logic [SB*8-1:0] m_hold_data = '0;
    logic [15:0]     m_fcnt = 16'h0000;
    logic            m_busy = 1'b0;
    logic            m_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a list of slot bytes: bit 8 = K flag, bit 9 = last checksum byte.
    task automatic build_frame();
        int          sum;
        logic [15:0] cs;
        logic [7:0]  b;
        sum = int'(m_hold_addr);
        m_slots.push_back(32'h15C);
        m_slots.push_back(int'(m_hold_addr));
        for (int i = 0; i < SB; i++) begin
            b = m_hold_data[i*8 +: 8];
            sum = sum + int'(b);
            m_slots.push_back(int'(b));
        end
        m_slots.push_back(32'h13C);
        cs = 16'hFFFF - 16'(sum);
        m_slots.push_back(int'(cs[15:8]));
        m_slots.push_back(int'(cs[7:0]) + 512);
        for (int i = 0; i < GS; i++) m_slots.push_back(0);
    endtask

    task automatic step();
        logic       ev_e, sr_e, ek, dk;
        logic [7:0] el, dl;
        int         e;
        exp_t       x;
        @(negedge tx_clk);
        aresetn = s_rstn; en = s_en; dbus = s_dbus; ev_valid = s_evv; ev_code = s_evc;
        seg_valid = s_sv; seg_addr = s_sa; seg_data = s_sd;
        #1;
        ev_e = s_rstn && s_en && (m_k % CP != 0) && !(BP != 0 && m_k % BP == 0);
        sr_e = s_rstn && s_en && !m_hold_full;
        check("ev_ready", 32'(ev_ready), 32'(ev_e));
        check("seg_ready", 32'(seg_ready), 32'(sr_e));
        if (ev_valid && ev_ready) hs_cnt++;
        m_acc = 1'b0;
        el = 8'h00; ek = 1'b0; dl = 8'h00; dk = 1'b0;
        if (!s_rstn) begin
            m_k = 0; m_slots.delete(); m_hold_full = 1'b0; m_fcnt = 16'h0000; m_busy = 1'b0;
        end else if (!s_en) begin
            m_k = 0; m_slots.delete(); m_busy = 1'b0;
        end else begin
            if (m_k % CP == 0) begin
                el = 8'hBC; ek = 1'b1;
            end else if (BP != 0 && m_k % BP == 0) begin
                el = 8'h7E;
            end else if (s_evv) begin
                el = s_evc;
            end
            if (m_k % 2 == 0) begin
                dl = s_dbus;
            end else begin
                if (m_slots.size() == 0 && m_hold_full) begin
                    build_frame();
                    m_hold_full = 1'b0;
                end
                if (m_slots.size() != 0) begin
                    e = m_slots.pop_front();
                    dl = e[7:0];
                    dk = e[8];
                    if (e[9]) m_fcnt = m_fcnt + 16'd1;
                end
                m_busy = (m_slots.size() != 0);
            end
            if (s_sv && sr_e) begin
                m_hold_full = 1'b1; m_hold_addr = s_sa; m_hold_data = s_sd; m_acc = 1'b1;
            end
            m_k++;
        end
        x.d = {dl, el}; x.k = {dk, ek}; x.b = m_busy; x.fc = m_fcnt;
        exp_q.push_back(x);
        if (s_glitch && s_rstn) begin
            #1 aresetn = 1'b0;
            #1 aresetn = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_frame();
        s_sa = 8'($urandom);
        for (int i = 0; i < SB / 4; i++) s_sd[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 2) == 0) s_sd[15:0] = 16'h3C5C;
    endtask

    task automatic offer_once();
        s_sv = 1'b1;
        step();
        s_sv = 1'b0;
    endtask

    // monitor: one expected word per edge after each stimulus cycle
    initial begin
        exp_t x;
        forever begin
            @(posedge tx_clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(x.d));
                check("tx_charisk", 32'(tx_charisk), 32'(x.k));
                check("busy", 32'(busy), 32'(x.b));
                check("frame_cnt", 32'(frame_cnt), 32'(x.fc));
                if (tx_data[7:0] == 8'h11 && !tx_charisk[0]) ev11_cnt++;
            end
        end
    end

    initial begin
        logic [7:0] tv [SB];
        int         bound;
        tv = '{8'h00, 8'h8B, 8'hFC, 8'h7B, 8'h00, 8'h00, 8'h00, 8'h07,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
        aresetn = 1'b0; en = 1'b0; dbus = 8'h00; ev_valid = 1'b0; ev_code = 8'h00;
        seg_valid = 1'b0; seg_addr = 8'h00; seg_data = '0;

        // reset with en high
        s_en = 1'b1;
        run(3);
        @(posedge tx_clk); #2;
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_charisk", 32'(tx_charisk), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("rst_seg_ready", 32'(seg_ready), 32'h0);
        check("rst_ev_ready", 32'(ev_ready), 32'h0);

        // known-checksum frame, bus slots at 0xA5
        s_rstn = 1'b1; s_dbus = 8'hA5; s_sa = 8'hFF;
        for (int i = 0; i < SB; i++) s_sd[i*8 +: 8] = tv[i];
        offer_once();
        run(50);
        check("frame1_cnt", 32'(frame_cnt), 32'd1);

        // commas, beacons and held events
        hs_cnt = 0; ev11_cnt = 0;
        s_evv = 1'b1; s_evc = 8'h11;
        run(60);
        s_evv = 1'b0;
        run(2);
        check("ev_words_vs_handshakes", 32'(ev11_cnt), 32'(hs_cnt));

        // back-to-back: second offered during DATA, third waits on the hold
        rand_frame(); offer_once();
        run(12);
        rand_frame(); offer_once();
        rand_frame(); s_sv = 1'b1;
        bound = 0;
        m_acc = 1'b0;
        while (!m_acc && bound < 200) begin
            step();
            bound++;
        end
        s_sv = 1'b0;
        check("third_accept_in_time", 32'(m_acc), 32'h1);
        run(150);
        check("b2b_frame_cnt", 32'(frame_cnt), 32'd4);

        // abort in DATA with a frame waiting in the hold
        rand_frame(); offer_once();
        run(12);
        rand_frame(); offer_once();
        s_en = 1'b0;
        run(3);
        s_en = 1'b1;
        run(120);
        check("abort_frame_cnt", 32'(frame_cnt), 32'd5);

        // glitches between edges, then a real reset mid-frame
        rand_frame(); offer_once();
        run(10);
        s_glitch = 1'b1; run(3); s_glitch = 1'b0;
        s_rstn = 1'b0; run(1); s_rstn = 1'b1;
        run(5);
        check("midframe_rst_cnt", 32'(frame_cnt), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_rstn   = ($urandom_range(0, 499) != 0);
            s_en     = ($urandom_range(0, 199) != 0);
            s_dbus   = 8'($urandom);
            s_evv    = 1'($urandom);
            s_evc    = 8'($urandom);
            s_sv     = ($urandom_range(0, 3) == 0);
            s_glitch = ($urandom_range(0, 49) == 0);
            if (s_sv) rand_frame();
            step();
        end

        // frame counter wrap
        s_rstn = 1'b1; s_en = 1'b1; s_sv = 1'b0; s_glitch = 1'b0;
        bound = 0;
        while ((m_slots.size() != 0 || m_hold_full) && bound < 300) begin
            step();
            bound++;
        end
        check("drained_before_wrap", 32'(m_slots.size() == 0 && !m_hold_full), 32'h1);
        @(posedge tx_clk); #2;
        force dut.frame_cnt_r = 16'hFFFF;
        #1;
        release dut.frame_cnt_r;
        m_fcnt = 16'hFFFF;
        rand_frame(); offer_once();
        run(60);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'h0);

        run(2);
        @(posedge tx_clk); #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
